data_compression: RTL and testbench

Streaming encoder that is the transmit-side counterpart of data_decompression. Takes 24-bit raw words made of four 6-bit symbols and emits 12-bit compressed words, one 2-bit code per symbol, using the same codebook (c1..c4 / e1..e4) the receiver decodes with. Encodes one symbol lane per cycle behind a valid/ready handshake on both sides, and flags symbols that are not in the codebook.

---
 rtl/data_compression_if.sv | 31 +++
 rtl/data_compression.sv | 149 ++++++++++++++
 tb/tb_data_compression.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_compression_if.sv
// Raw-word in / compressed-word out stream bundle for the codebook encoder.
// master = upstream/downstream side, slave = encoder side.
interface data_compression_if #(
    parameter int RAW_W = 24,
    parameter int CMP_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [RAW_W-1:0] raw_data;
    logic             out_valid;
    logic             out_ready;
    logic [CMP_W-1:0] compress_data;

    modport master (
        output in_valid,
        output raw_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  compress_data
    );

    modport slave (
        input  in_valid,
        input  raw_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output compress_data
    );
endinterface

// File: rtl/data_compression.sv
// Codebook encoder: four 6-bit symbols -> four 2-bit codes plus per-lane miss flags.
// Latency 4 edges accept-to-out_valid; one word in flight, output held until out_ready.
module data_compression #(
    parameter int SYM_W  = 6,
    parameter int CODE_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SYM_W-1:0]  c1,
    input  logic [SYM_W-1:0]  c2,
    input  logic [SYM_W-1:0]  c3,
    input  logic [SYM_W-1:0]  c4,
    input  logic [CODE_W-1:0] e1,
    input  logic [CODE_W-1:0] e2,
    input  logic [CODE_W-1:0] e3,
    input  logic [CODE_W-1:0] e4,
    data_compression_if.slave bus,
    output logic [CNT_W-1:0]  miss_count,
    output logic              busy
);
    localparam int LANES = 4;
    localparam int CMP_W = CODE_W*LANES + LANES;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;
    logic [1:0]             r_lane;
    logic [SYM_W*LANES-1:0] r_raw;
    logic [SYM_W-1:0]       r_c [LANES];
    logic [CODE_W-1:0]      r_e [LANES];
    logic [CMP_W-1:0]       r_cdata;
    logic [CNT_W-1:0]       r_miss;
    logic [SYM_W-1:0]       w_sym;
    logic                   w_hit;
    logic [CODE_W-1:0]      w_code;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ENCODE;
                end
            end
            S_ENCODE: begin
                if (r_lane == 2'd3) begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_OUTPUT);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_sym = r_raw[SYM_W-1:0];
        case (r_lane)
            2'd1:    w_sym = r_raw[2*SYM_W-1:SYM_W];
            2'd2:    w_sym = r_raw[3*SYM_W-1:2*SYM_W];
            2'd3:    w_sym = r_raw[4*SYM_W-1:3*SYM_W];
            default: w_sym = r_raw[SYM_W-1:0];
        endcase
    end

    // Scan from c4 down to c1 so the lowest-numbered matching entry wins.
    always_comb begin
        w_hit  = 1'b0;
        w_code = '0;
        for (int k = LANES-1; k >= 0; k--) begin
            if (w_sym == r_c[k]) begin
                w_hit  = 1'b1;
                w_code = r_e[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_raw   <= '0;
            r_cdata <= '0;
            r_miss  <= '0;
            r_lane  <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_c[k] <= '0;
                r_e[k] <= '0;
            end
        end else if (w_accept) begin
            r_raw   <= bus.raw_data;
            r_c[0]  <= c1;
            r_c[1]  <= c2;
            r_c[2]  <= c3;
            r_c[3]  <= c4;
            r_e[0]  <= e1;
            r_e[1]  <= e2;
            r_e[2]  <= e3;
            r_e[3]  <= e4;
            r_cdata <= '0;
            r_lane  <= '0;
        end else if (r_state == S_ENCODE) begin
            for (int k = 0; k < LANES; k++) begin
                if (r_lane == k[1:0]) begin
                    r_cdata[CODE_W*k +: CODE_W] <= w_code;
                    r_cdata[CODE_W*LANES + k]   <= !w_hit;
                end
            end
            if (!w_hit && (r_miss != {CNT_W{1'b1}})) begin
                r_miss <= r_miss + CNT_W'(1);
            end
            r_lane <= r_lane + 2'd1;
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.compress_data = r_cdata;
    assign miss_count        = r_miss;
    assign busy              = r_busy;
endmodule

// File: tb/tb_data_compression.sv
// Directed bench for data_compression: codebook hits/misses, latency, backpressure,
// snapshot isolation, priority on duplicates and mid-encode reset.
module tb_data_compression;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  c1, c2, c3, c4;
    logic [1:0]  e1, e2, e3, e4;
    logic [15:0] miss_count;
    logic        busy;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_miss = 0;

    localparam logic [23:0] WORD_A = {6'h3F, 6'h15, 6'h0A, 6'h05};
    localparam logic [23:0] WORD_B = {6'h3F, 6'h15, 6'h20, 6'h05};

    data_compression_if bus ();

    data_compression dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .c4         (c4),
        .e1         (e1),
        .e2         (e2),
        .e3         (e3),
        .e4         (e4),
        .bus        (bus),
        .miss_count (miss_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_codebook();
        c1 = 6'h05; c2 = 6'h0A; c3 = 6'h15; c4 = 6'h3F;
        e1 = 2'd0;  e2 = 2'd1;  e3 = 2'd2;  e4 = 2'd3;
    endtask

    // Receiver-side model: each code maps back to the first codebook symbol carrying it.
    function automatic logic [23:0] decode(input logic [11:0] cd);
        logic [23:0] res;
        logic [1:0]  code;
        logic [5:0]  sym;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            code = cd[2*k +: 2];
            sym  = 6'h00;
            if (e4 == code) sym = c4;
            if (e3 == code) sym = c3;
            if (e2 == code) sym = c2;
            if (e1 == code) sym = c1;
            res[6*k +: 6] = sym;
        end
        return res;
    endfunction

    task automatic accept(input logic [23:0] raw, input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.raw_data = raw;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_rdy_drop"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
    endtask

    task automatic run_word(input logic [23:0] raw, input logic [11:0] exp_cd,
                            input string tag, input bit mutate, input bit roundtrip);
        bus.out_ready = 1'b1;
        accept(raw, tag);
        if (mutate) c1 = 6'h3F;
        wait_out(tag);
        check({tag, "_cd"}, 32'(bus.compress_data), 32'(exp_cd));
        check({tag, "_miss"}, 32'(miss_count), 32'(exp_miss));
        if (roundtrip) check({tag, "_rt"}, 32'(decode(bus.compress_data)), 32'(raw));
        tick();
        check({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_ret"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.raw_data  = '0;
        bus.out_ready = 1'b0;
        set_codebook();
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_cd", 32'(bus.compress_data), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();
        check("rdy_after_rst", 32'(bus.in_ready), 32'd1);

        run_word(WORD_A, 12'h0E4, "hit", 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            exp_miss++;
            run_word(WORD_B, 12'h2E0, "miss", 1'b0, 1'b0);
        end

        // Backpressure: output must hold while everything upstream churns.
        bus.out_ready = 1'b0;
        accept(WORD_A, "bp");
        wait_out("bp");
        for (int i = 0; i < 10; i++) begin
            bus.raw_data = 24'(i * 24'h13579);
            bus.in_valid = i[0];
            c1 = 6'(i + 1);
            e2 = 2'(i);
            tick();
            check("bp_cd_hold", 32'(bus.compress_data), 32'h0E4);
            check("bp_ov_hold", 32'(bus.out_valid), 32'd1);
            check("bp_rdy_low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        set_codebook();
        bus.out_ready = 1'b1;
        tick();
        check("bp_ov_clr", 32'(bus.out_valid), 32'd0);
        check("bp_rdy_ret", 32'(bus.in_ready), 32'd1);
        check("bp_cd_keep", 32'(bus.compress_data), 32'h0E4);
        check("bp_miss", 32'(miss_count), 32'(exp_miss));

        run_word(WORD_A, 12'h0E4, "snap", 1'b1, 1'b0);
        set_codebook();

        c2 = 6'h05; e1 = 2'd2; e2 = 2'd1;
        exp_miss++;
        run_word(WORD_A, 12'h2E2, "dup", 1'b0, 1'b0);
        set_codebook();

        // Reset while lane 2 is about to be encoded.
        bus.out_ready = 1'b1;
        accept(WORD_A, "rst_mid");
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rstm_out_valid", 32'(bus.out_valid), 32'd0);
        check("rstm_miss", 32'(miss_count), 32'd0);
        check("rstm_in_ready", 32'(bus.in_ready), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        tick();
        check("rstm_rdy_ret", 32'(bus.in_ready), 32'd1);
        check("rstm_no_out", 32'(bus.out_valid), 32'd0);
        exp_miss = 1;
        run_word(WORD_B, 12'h2E0, "post_rst", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
